// File: rtl/tdm_vocoder_mixer.sv
// Time-multiplexed vocoder mixer: one shared multiplier walks the captured frame,
// products are accumulated at full precision, then scaled and saturated to OUT_WIDTH.
module tdm_vocoder_mixer #(
  parameter int NUM_CHANNELS  = 8,
  parameter int CARRIER_WIDTH = 32,
  parameter int ENV_WIDTH     = 32,
  parameter int OUT_WIDTH     = 24,
  parameter int SHIFT_WIDTH   = 5,
  parameter int BASE_SHIFT    = 24
) (
  input  logic                                  clk_in,
  input  logic                                  n_rst_in,
  input  logic                                  valid_in,
  input  logic [NUM_CHANNELS*CARRIER_WIDTH-1:0] carrier_in,
  input  logic [NUM_CHANNELS*ENV_WIDTH-1:0]     envelope_in,
  input  logic [NUM_CHANNELS-1:0]               chan_en_in,
  input  logic [SHIFT_WIDTH-1:0]                shift_in,
  output logic [OUT_WIDTH-1:0]                  mixed_out,
  output logic                                  valid_out,
  output logic                                  sat_out,
  output logic                                  busy_out,
  output logic                                  overrun_out
);
  localparam int ACC_WIDTH  = CARRIER_WIDTH + ENV_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int PROD_WIDTH = CARRIER_WIDTH + ENV_WIDTH;
  localparam int CNT_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t                                      state;
  logic [NUM_CHANNELS-1:0][CARRIER_WIDTH-1:0]  carrier_q;
  logic [NUM_CHANNELS-1:0][ENV_WIDTH-1:0]      env_q;
  logic [NUM_CHANNELS-1:0]                     chan_en_q;
  logic [SHIFT_WIDTH-1:0]                      shift_q;
  logic [CNT_W-1:0]                            cnt;
  logic signed [PROD_WIDTH-1:0]                prod, prod_next;
  logic                                        prod_vld;
  logic signed [ACC_WIDTH-1:0]                 acc, scaled;
  logic [31:0]                                 shamt;
  logic                                        clip_hi, clip_lo;

  always_comb begin
    prod_next = '0;
    if (chan_en_q[cnt])
      prod_next = $signed(carrier_q[cnt]) * $signed(env_q[cnt]);
  end

  // >>> on a signed accumulator floors toward -inf, which is the rounding we want
  always_comb begin
    shamt   = 32'(BASE_SHIFT) + 32'(shift_q);
    scaled  = acc >>> shamt;
    clip_hi = scaled > SAT_MAX;
    clip_lo = scaled < SAT_MIN;
  end

  always_ff @(posedge clk_in) begin
    if (!n_rst_in) begin
      state       <= IDLE;
      carrier_q   <= '0;
      env_q       <= '0;
      chan_en_q   <= '0;
      shift_q     <= '0;
      cnt         <= '0;
      prod        <= '0;
      prod_vld    <= 1'b0;
      acc         <= '0;
      mixed_out   <= '0;
      valid_out   <= 1'b0;
      sat_out     <= 1'b0;
      busy_out    <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      sat_out   <= 1'b0;
      if (valid_in && busy_out) overrun_out <= 1'b1;
      // product register lags the multiply by one cycle
      prod_vld <= (state == MAC);
      if (prod_vld) acc <= acc + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      case (state)
        IDLE: if (valid_in) begin
          carrier_q <= carrier_in;
          env_q     <= envelope_in;
          chan_en_q <= chan_en_in;
          shift_q   <= shift_in;
          acc       <= '0;
          cnt       <= '0;
          busy_out  <= 1'b1;
          state     <= MAC;
        end
        MAC: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(NUM_CHANNELS-1)) state <= DRAIN;
        end
        DRAIN: state <= OUT;
        OUT: begin
          if (clip_hi)      mixed_out <= {1'b0, {(OUT_WIDTH-1){1'b1}}};
          else if (clip_lo) mixed_out <= {1'b1, {(OUT_WIDTH-1){1'b0}}};
          else              mixed_out <= scaled[OUT_WIDTH-1:0];
          sat_out   <= clip_hi | clip_lo;
          valid_out <= 1'b1;
          busy_out  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdm_vocoder_mixer.sv
// Scoreboard bench for tdm_vocoder_mixer at default parameters.
module tb_tdm_vocoder_mixer;
  localparam int N = 8, CW = 32, EW = 32, OW = 24, SW = 5;
  localparam int LAT = N + 3;

  logic              clk = 0;
  logic              n_rst;
  logic              valid_in;
  logic [N*CW-1:0]   carrier_in;
  logic [N*EW-1:0]   envelope_in;
  logic [N-1:0]      chan_en_in;
  logic [SW-1:0]     shift_in;
  logic [OW-1:0]     mixed_out;
  logic              valid_out, sat_out, busy_out, overrun_out;

  tdm_vocoder_mixer dut (
    .clk_in(clk), .n_rst_in(n_rst), .valid_in(valid_in),
    .carrier_in(carrier_in), .envelope_in(envelope_in), .chan_en_in(chan_en_in),
    .shift_in(shift_in), .mixed_out(mixed_out), .valid_out(valid_out),
    .sat_out(sat_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;

  typedef struct { longint mixed; bit sat; int t0; } exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   errs = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mixed", $signed(mixed_out), e.mixed);
        chk("sat", sat_out, e.sat);
        chk("latency", cyc - e.t0, LAT);
      end
    end else if (sat_out) chk("sat_idle", sat_out, 0);
  end

  function automatic void model(input logic [N*CW-1:0] c, input logic [N*EW-1:0] e,
                                input logic [N-1:0] m, input logic [SW-1:0] sh,
                                output longint mx, output bit sat);
    longint sum = 0, s;
    for (int k = 0; k < N; k++)
      if (m[k]) sum += longint'($signed(c[k*CW +: CW])) * longint'($signed(e[k*EW +: EW]));
    s   = sum >>> (24 + int'(sh));
    sat = 1'b0;
    mx  = s;
    if (s > 64'sd8388607)       begin mx = 8388607;  sat = 1'b1; end
    else if (s < -64'sd8388608) begin mx = -8388608; sat = 1'b1; end
  endfunction

  // Called just after a posedge; strobes one frame and scrambles inputs after capture.
  task automatic send(input logic [N*CW-1:0] c, input logic [N*EW-1:0] e,
                      input logic [N-1:0] m, input logic [SW-1:0] sh,
                      input longint mx, input bit sat, input bit push);
    exp_t x;
    carrier_in = c; envelope_in = e; chan_en_in = m; shift_in = sh; valid_in = 1'b1;
    x.mixed = mx; x.sat = sat; x.t0 = cyc;
    if (push) exp_q.push_back(x);
    @(posedge clk); #1;
    valid_in = 1'b0;
    carrier_in = {N{32'hdead_beef}}; envelope_in = {N{32'h1234_5678}};
    chan_en_in = '1; shift_in = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [N*CW-1:0] c;
  logic [N*EW-1:0] e;
  longint mx;
  bit     sat;

  initial begin
    n_rst = 1'b0; valid_in = 1'b0; carrier_in = '0; envelope_in = '0;
    chan_en_in = '0; shift_in = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_mixed", mixed_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_sat", sat_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_overrun", overrun_out, 0);
    n_rst = 1'b1;

    // single channel unity-ish gain
    c = '0; e = '0; c[31:0] = 32'sd1 <<< 24; e[31:0] = 32'sd1 <<< 20;
    send(c, e, 8'hFF, 5'd0, 64'sd1048576, 1'b0, 1'b1);
    chk("busy_mid", busy_out, 1);
    wait_done();
    chk("hold_mixed", $signed(mixed_out), 64'sd1048576);

    // all channels, negative envelope, extra shift
    for (int k = 0; k < N; k++) begin c[k*CW +: CW] = 32'sd1 <<< 24; e[k*EW +: EW] = -(32'sd1 <<< 20); end
    send(c, e, 8'hFF, 5'd3, -64'sd1048576, 1'b0, 1'b1); wait_done();
    send(c, e, 8'h0F, 5'd3, -64'sd524288, 1'b0, 1'b1); wait_done();
    send(c, e, 8'h00, 5'd3, 64'sd0, 1'b0, 1'b1); wait_done();

    // saturation both ways
    c = '0; e = '0; c[31:0] = 32'sd1 <<< 30; e[31:0] = 32'sd1 <<< 30;
    send(c, e, 8'hFF, 5'd0, 64'sd8388607, 1'b1, 1'b1); wait_done();
    c[31:0] = -(32'sd1 <<< 30);
    send(c, e, 8'hFF, 5'd0, -64'sd8388608, 1'b1, 1'b1); wait_done();

    // floor rounding of a tiny negative sum
    c = '0; e = '0; c[31:0] = -32'sd1; e[31:0] = 32'sd1;
    send(c, e, 8'hFF, 5'd0, -64'sd1, 1'b0, 1'b1); wait_done();

    // random frames against the reference model
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        c[k*CW +: CW] = int'($urandom_range(0, 268435455)) - 134217728;
        e[k*EW +: EW] = int'($urandom_range(0, 2097151)) - 1048576;
      end
      chan_en_in = 8'($urandom);
      shift_in   = 5'($urandom_range(0, 7));
      model(c, e, chan_en_in, shift_in, mx, sat);
      send(c, e, chan_en_in, shift_in, mx, sat, 1'b1); wait_done();
    end

    // overrun: second strobe mid-frame is dropped
    c = '0; e = '0; c[31:0] = 32'sd1 <<< 24; e[31:0] = 32'sd3 <<< 20;
    send(c, e, 8'hFF, 5'd0, 64'sd3145728, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    send(c, c, 8'hFF, 5'd0, 64'sd0, 1'b0, 1'b0);
    wait_done();
    repeat (15) @(posedge clk); #1;
    chk("overrun_set", overrun_out, 1);
    send(c, e, 8'hFF, 5'd1, 64'sd1572864, 1'b0, 1'b1); wait_done();
    chk("overrun_sticky", overrun_out, 1);

    // reset mid-MAC abandons the frame
    send(c, e, 8'hFF, 5'd0, 64'sd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk("mrst_mixed", mixed_out, 0);
    chk("mrst_busy", busy_out, 0);
    chk("mrst_overrun", overrun_out, 0);
    chk("mrst_valid", valid_out, 0);
    repeat (20) @(posedge clk); #1;
    c = '0; e = '0; c[63:32] = 32'sd5 <<< 24; e[63:32] = -(32'sd1 <<< 16);
    send(c, e, 8'h02, 5'd2, -64'sd81920, 1'b0, 1'b1); wait_done();
    chk("final_overrun", overrun_out, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
